span_shader: RTL and testbench

- Parametrised successor to the scanline span drawer: walks one horizontal span X1→X2, interpolates depth plus NCH colour channels with saturating fixed-point steps, and performs a depth test against a generation-tagged Z line buffer.
- Writes passing pixels into a ping-pong colour line buffer.
- Adds over the previous generation: configurable widths, channel count and RAM read latency; selectable depth function; depth-write mask; valid/ready handshake with pipeline drain.
- Sits between the triangle edge walker (span producer) and the scanout line buffers.

---
 rtl/span_pkg.sv | 24 ++
 rtl/sat_step_acc.sv | 55 +++++
 rtl/span_shader.sv | 242 ++++++++++++++++++++++++
 tb/tb_span_shader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/span_pkg.sv
`default_nettype none
// ============================================================================
// Module   : span_pkg
// Brief    : Shared encodings and helpers for the span shader.
// Revision : 1.0
// ============================================================================
package span_pkg;

    localparam logic [1:0] ZF_LESS   = 2'd0;
    localparam logic [1:0] ZF_LEQUAL = 2'd1;
    localparam logic [1:0] ZF_ALWAYS = 2'd2;
    localparam logic [1:0] ZF_NEVER  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One extra bit holds the carry (positive step) or borrow (negative step).
    function automatic int sat_sum_width(input int w);
        return w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_step_acc.sv
`default_nettype none
// ============================================================================
// Module   : sat_step_acc
// Brief    : Unsigned accumulator with signed step, clamped to [0, 2^W-1].
// Revision : 1.0
// ============================================================================
module sat_step_acc
    import span_pkg::*;
#(
    parameter int W = 22
) (
    input  logic         clk100,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] init,
    input  logic [W:0]   step,
    input  logic         step_en,
    output logic [W-1:0] acc
);

    localparam int c_SUM_W = sat_sum_width(W);

    logic [W-1:0]       r_acc;
    logic [W:0]         r_step;
    logic [c_SUM_W-1:0] w_sum;
    logic [W-1:0]       w_next;

    // The top bit of the modular sum flags overflow for a positive step and
    // underflow for a negative one.
    always_comb begin
        w_sum = {1'b0, r_acc} + r_step;
        if (!w_sum[c_SUM_W-1])
            w_next = w_sum[W-1:0];
        else if (r_step[W])
            w_next = '0;
        else
            w_next = '1;
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_acc  <= '0;
            r_step <= '0;
        end else if (load) begin
            r_acc  <= init;
            r_step <= step;
        end else if (step_en) begin
            r_acc  <= w_next;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/span_shader.sv
`default_nettype none
// ============================================================================
// Module   : span_shader
// Brief    : Horizontal span walker with depth/colour interpolation and a
//            generation-tagged depth test feeding ping-pong line buffers.
// Revision : 1.0
// ============================================================================
module span_shader
    import span_pkg::*;
#(
    parameter int XW    = 10,
    parameter int ZW    = 26,
    parameter int ZOUT  = 16,
    parameter int NCH   = 3,
    parameter int CW    = 22,
    parameter int CF    = 10,
    parameter int RDLAT = 2
) (
    input  logic                   clk100,
    input  logic                   reset,
    input  logic                   span_valid,
    output logic                   span_ready,
    input  logic [XW-1:0]          x1,
    input  logic [XW-1:0]          x2,
    input  logic [ZW-1:0]          z1,
    input  logic [ZW:0]            dz,
    input  logic [NCH*CW-1:0]      c1,
    input  logic [NCH*(CW+1)-1:0]  dc,
    input  logic [1:0]             zfunc,
    input  logic                   zmask,
    input  logic                   next_line,
    input  logic                   next_frame,
    output logic [XW-1:0]          z_raddr,
    input  logic [ZOUT:0]          z_rdata,
    output logic [XW-1:0]          z_waddr,
    output logic [ZOUT:0]          z_wdata,
    output logic                   z_we,
    output logic [XW:0]            c_addr,
    output logic [NCH*(CW-CF)-1:0] c_data,
    output logic                   c_we
);

    localparam int c_CI  = CW - CF;
    localparam int c_CDW = NCH * c_CI;

    logic [1:0]      r_state;
    logic [XW-1:0]   r_x;
    logic [XW-1:0]   r_xend;
    logic            r_dir;
    logic [1:0]      r_zfunc;
    logic            r_zmask;
    logic            r_pol;
    logic [2:0]      r_drain;

    logic            r_p_valid [RDLAT];
    logic [XW-1:0]   r_p_x     [RDLAT];
    logic [ZOUT-1:0] r_p_z     [RDLAT];
    logic [c_CDW-1:0] r_p_col  [RDLAT];

    logic            r_z_we;
    logic            r_c_we;
    logic [XW-1:0]   r_z_waddr;
    logic [ZOUT:0]   r_z_wdata;
    logic [XW:0]     r_c_addr;
    logic [c_CDW-1:0] r_c_data;

    logic            w_accept;
    logic            w_issue;
    logic            w_dir;
    logic [XW-1:0]   w_x_next;
    logic [ZW:0]     w_dz_eff;
    logic [ZW-1:0]   w_zacc;
    logic [CW-1:0]   w_cacc [NCH];
    logic [c_CDW-1:0] w_cint;
    logic [ZOUT-1:0] w_znew;
    logic [ZOUT-1:0] w_stored;
    logic            w_pass;
    logic            w_unused_zfrac;

    assign w_accept = (r_state == ST_IDLE) && span_valid;
    assign w_issue  = (r_state == ST_RUN);
    assign w_dir    = (x2 > x1);
    assign w_x_next = r_dir ? (r_x + XW'(1)) : (r_x - XW'(1));
    // Steps arrive expressed for increasing X; flip them for right-to-left spans.
    assign w_dz_eff = w_dir ? dz : -dz;

    sat_step_acc #(.W(ZW)) u_zacc (
        .clk100  (clk100),
        .reset   (reset),
        .load    (w_accept),
        .init    (z1),
        .step    (w_dz_eff),
        .step_en (w_issue),
        .acc     (w_zacc)
    );

    assign w_unused_zfrac = ^w_zacc[ZW-ZOUT-1:0];

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [CW:0] w_dc_in;
            logic [CW:0] w_dc_eff;
            logic        w_unused_cfrac;

            assign w_dc_in  = dc[i*(CW+1) +: CW+1];
            assign w_dc_eff = w_dir ? w_dc_in : -w_dc_in;

            sat_step_acc #(.W(CW)) u_cacc (
                .clk100  (clk100),
                .reset   (reset),
                .load    (w_accept),
                .init    (c1[i*CW +: CW]),
                .step    (w_dc_eff),
                .step_en (w_issue),
                .acc     (w_cacc[i])
            );

            assign w_cint[i*c_CI +: c_CI] = w_cacc[i][CW-1 -: c_CI];
            assign w_unused_cfrac         = ^w_cacc[i][CF-1:0];
        end
    endgenerate

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_xend  <= '0;
            r_dir   <= 1'b0;
            r_zfunc <= ZF_LESS;
            r_zmask <= 1'b0;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (span_valid) begin
                        r_x     <= x1;
                        r_xend  <= x2;
                        r_dir   <= w_dir;
                        r_zfunc <= zfunc;
                        r_zmask <= zmask;
                        if (x1 == x2) begin
                            r_state <= ST_DRAIN;
                            r_drain <= '0;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_x <= w_x_next;
                    if (w_x_next == r_xend) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 3'(RDLAT);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == '0)
                        r_state <= ST_IDLE;
                    else
                        r_drain <= r_drain - 3'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (reset)
            r_pol <= 1'b1;
        else if (next_frame)
            r_pol <= 1'b1;
        else if (next_line)
            r_pol <= ~r_pol;
    end

    // Pixel attributes travel alongside the outstanding Z read.
    always_ff @(posedge clk100) begin
        if (reset) begin
            for (int i = 0; i < RDLAT; i++)
                r_p_valid[i] <= 1'b0;
        end else begin
            r_p_valid[0] <= w_issue;
            r_p_x[0]     <= r_x;
            r_p_z[0]     <= w_zacc[ZW-1 -: ZOUT];
            r_p_col[0]   <= w_cint;
            for (int i = 1; i < RDLAT; i++) begin
                r_p_valid[i] <= r_p_valid[i-1];
                r_p_x[i]     <= r_p_x[i-1];
                r_p_z[i]     <= r_p_z[i-1];
                r_p_col[i]   <= r_p_col[i-1];
            end
        end
    end

    always_comb begin
        w_znew   = r_p_z[RDLAT-1];
        w_stored = z_rdata[ZOUT-1:0];
        w_pass   = 1'b0;
        if (z_rdata[ZOUT] != r_pol) begin
            w_pass = 1'b1;
        end else begin
            case (r_zfunc)
                ZF_LESS:   w_pass = (w_znew <  w_stored);
                ZF_LEQUAL: w_pass = (w_znew <= w_stored);
                ZF_ALWAYS: w_pass = 1'b1;
                ZF_NEVER:  w_pass = 1'b0;
                default:   w_pass = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_z_we    <= 1'b0;
            r_c_we    <= 1'b0;
            r_z_waddr <= '0;
            r_z_wdata <= '0;
            r_c_addr  <= '0;
            r_c_data  <= '0;
        end else begin
            r_z_we <= r_p_valid[RDLAT-1] && w_pass && r_zmask;
            r_c_we <= r_p_valid[RDLAT-1] && w_pass;
            if (r_p_valid[RDLAT-1]) begin
                r_z_waddr <= r_p_x[RDLAT-1];
                r_z_wdata <= {r_pol, w_znew};
                r_c_addr  <= {r_pol, r_p_x[RDLAT-1]};
                r_c_data  <= r_p_col[RDLAT-1];
            end
        end
    end

    assign span_ready = (r_state == ST_IDLE);
    assign z_raddr    = r_x;
    assign z_we       = r_z_we;
    assign c_we       = r_c_we;
    assign z_waddr    = r_z_waddr;
    assign z_wdata    = r_z_wdata;
    assign c_addr     = r_c_addr;
    assign c_data     = r_c_data;

endmodule
`default_nettype wire

// File: tb/tb_span_shader.sv
`default_nettype none
// ============================================================================
// Module   : tb_span_shader
// Brief    : Randomised scoreboard bench for span_shader with a Z RAM model.
// Revision : 1.0
// ============================================================================
module tb_span_shader;

    localparam int XW    = 10;
    localparam int ZW    = 26;
    localparam int ZOUT  = 16;
    localparam int NCH   = 3;
    localparam int CW    = 22;
    localparam int CF    = 10;
    localparam int RDLAT = 2;
    localparam int CI    = CW - CF;
    localparam int CW1   = CW + 1;
    localparam int ZW1   = ZW + 1;

    logic                   clk100 = 1'b0;
    logic                   reset;
    logic                   span_valid;
    logic                   span_ready;
    logic [XW-1:0]          x1, x2;
    logic [ZW-1:0]          z1;
    logic [ZW:0]            dz;
    logic [NCH*CW-1:0]      c1;
    logic [NCH*(CW+1)-1:0]  dc;
    logic [1:0]             zfunc;
    logic                   zmask;
    logic                   next_line, next_frame;
    logic [XW-1:0]          z_raddr;
    logic [ZOUT:0]          z_rdata = '0;
    logic [XW-1:0]          z_waddr;
    logic [ZOUT:0]          z_wdata;
    logic                   z_we;
    logic [XW:0]            c_addr;
    logic [NCH*CI-1:0]      c_data;
    logic                   c_we;

    span_shader #(
        .XW(XW), .ZW(ZW), .ZOUT(ZOUT), .NCH(NCH), .CW(CW), .CF(CF), .RDLAT(RDLAT)
    ) dut (
        .clk100(clk100), .reset(reset), .span_valid(span_valid), .span_ready(span_ready),
        .x1(x1), .x2(x2), .z1(z1), .dz(dz), .c1(c1), .dc(dc),
        .zfunc(zfunc), .zmask(zmask), .next_line(next_line), .next_frame(next_frame),
        .z_raddr(z_raddr), .z_rdata(z_rdata), .z_waddr(z_waddr), .z_wdata(z_wdata),
        .z_we(z_we), .c_addr(c_addr), .c_data(c_data), .c_we(c_we)
    );

    always #5 clk100 = ~clk100;

    longint cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    // Z RAM with a two-cycle read: address register, then data register.
    logic [ZOUT:0] zmem [1<<XW] = '{default: '0};
    logic [XW-1:0] ra_d = '0;
    always @(posedge clk100) begin
        ra_d    <= z_raddr;
        z_rdata <= zmem[ra_d];
        if (z_we) zmem[z_waddr] <= z_wdata;
    end

    typedef struct {
        int                x;
        bit                zwe;
        logic [ZOUT:0]     zwdata;
        logic [XW:0]       caddr;
        logic [NCH*CI-1:0] cdata;
        longint            cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    bit            m_pol  = 1'b1;
    logic [ZOUT:0] m_zbuf [1<<XW] = '{default: '0};
    longint        s_c1 [NCH];
    longint        s_dc [NCH];

    always @(negedge clk100) begin
        if (c_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got c_addr=%h c_data=%h z_we=%b at cyc %0d, required no write",
                         c_addr, c_data, z_we, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (c_addr !== mon_e.caddr || c_data !== mon_e.cdata || z_we !== mon_e.zwe ||
                    cyc != mon_e.cyc ||
                    (mon_e.zwe && (z_waddr !== XW'(mon_e.x) || z_wdata !== mon_e.zwdata))) begin
                    errors++;
                    $display("FAIL pixel_write: got cyc=%0d c_addr=%h c_data=%h z_we=%b z_waddr=%h z_wdata=%h, required cyc=%0d c_addr=%h c_data=%h z_we=%b z_waddr=%h z_wdata=%h",
                             cyc, c_addr, c_data, z_we, z_waddr, z_wdata,
                             mon_e.cyc, mon_e.caddr, mon_e.cdata, mon_e.zwe, XW'(mon_e.x), mon_e.zwdata);
                end
            end
        end else if (z_we) begin
            checks++;
            errors++;
            $display("FAIL z_we_without_c_we: got z_we=1 z_waddr=%h at cyc %0d, required z_we=0", z_waddr, cyc);
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic longint clampv(input longint v, input longint mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic longint rnd_signed(input int bits);
        longint mag;
        mag = longint'($urandom & ((32'd1 << bits) - 1));
        return ($urandom_range(0, 1) == 1) ? -mag : mag;
    endfunction

    // Reference: walk the span in plain integer arithmetic and predict every write.
    task automatic model_span(input int ax1, input int ax2, input longint az1, input longint adz,
                              input int azf, input bit azm, input longint pcyc);
        longint zmax = (longint'(1) << ZW) - 1;
        longint cmax = (longint'(1) << CW) - 1;
        bit     dir  = (ax2 > ax1);
        int     npix = dir ? ax2 - ax1 : ax1 - ax2;
        longint za   = az1;
        longint zs   = dir ? adz : -adz;
        longint ca [NCH];
        longint cs [NCH];
        for (int k = 0; k < NCH; k++) begin
            ca[k] = s_c1[k];
            cs[k] = dir ? s_dc[k] : -s_dc[k];
        end
        for (int i = 0; i < npix; i++) begin
            int            x;
            bit            pass;
            logic [ZOUT-1:0] znew;
            logic [ZOUT:0] st;
            exp_t          e;
            x    = dir ? ax1 + i : ax1 - i;
            znew = ZOUT'(za >> (ZW - ZOUT));
            st   = m_zbuf[x];
            if (st[ZOUT] != m_pol) pass = 1'b1;
            else begin
                case (azf)
                    0:       pass = (znew <  st[ZOUT-1:0]);
                    1:       pass = (znew <= st[ZOUT-1:0]);
                    2:       pass = 1'b1;
                    default: pass = 1'b0;
                endcase
            end
            if (pass) begin
                e.x      = x;
                e.zwe    = azm;
                e.zwdata = {m_pol, znew};
                e.caddr  = {m_pol, XW'(x)};
                e.cdata  = '0;
                for (int k = 0; k < NCH; k++) e.cdata[k*CI +: CI] = CI'(ca[k] >> CF);
                e.cyc    = pcyc + i + RDLAT + 1;
                exp_q.push_back(e);
                if (azm) m_zbuf[x] = {m_pol, znew};
            end
            za = clampv(za + zs, zmax);
            for (int k = 0; k < NCH; k++) ca[k] = clampv(ca[k] + cs[k], cmax);
        end
    endtask

    task automatic run_span(input int ax1, input int ax2, input longint az1, input longint adz,
                            input int azf, input bit azm, input bit do_reset);
        int npix = (ax2 > ax1) ? ax2 - ax1 : ax1 - ax2;
        int n    = 0;
        @(negedge clk100);
        chk("ready_before_accept", longint'(span_ready), 1);
        x1    = XW'(ax1);
        x2    = XW'(ax2);
        z1    = ZW'(az1);
        dz    = ZW1'(adz);
        zfunc = 2'(azf);
        zmask = azm;
        for (int k = 0; k < NCH; k++) begin
            c1[k*CW +: CW]   = CW'(s_c1[k]);
            dc[k*CW1 +: CW1] = CW1'(s_dc[k]);
        end
        span_valid = 1'b1;
        if (!do_reset) model_span(ax1, ax2, az1, adz, azf, azm, cyc + 1);
        @(negedge clk100);
        span_valid = 1'b0;
        if (npix > 0) chk("first_raddr", longint'(z_raddr), longint'(ax1));
        if (do_reset) begin
            @(negedge clk100);
            reset = 1'b1;
            @(negedge clk100);
            reset = 1'b0;
            m_pol = 1'b1;
            chk("reset_mid_c_we", longint'(c_we), 0);
            chk("reset_mid_z_we", longint'(z_we), 0);
            chk("reset_mid_ready", longint'(span_ready), 1);
            repeat (4) @(negedge clk100);
            return;
        end
        while (span_ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk100);
        end
        chk("ready_low_cycles", n, (npix > 0) ? npix + RDLAT + 1 : 1);
    endtask

    task automatic pulse_pol(input bit nl, input bit nf);
        @(negedge clk100);
        next_line  = nl;
        next_frame = nf;
        @(negedge clk100);
        next_line  = 1'b0;
        next_frame = 1'b0;
        if (nf) m_pol = 1'b1;
        else if (nl) m_pol = ~m_pol;
    endtask

    task automatic rand_colours();
        for (int k = 0; k < NCH; k++) begin
            s_c1[k] = longint'($urandom & ((32'd1 << CW) - 1));
            s_dc[k] = rnd_signed($urandom_range(4, CW));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint zr, dzr;
        reset = 1'b1; span_valid = 1'b0; x1 = '0; x2 = '0; z1 = '0; dz = '0;
        c1 = '0; dc = '0; zfunc = '0; zmask = 1'b0; next_line = 1'b0; next_frame = 1'b0;
        repeat (3) @(negedge clk100);
        chk("rst_span_ready", longint'(span_ready), 1);
        chk("rst_z_we", longint'(z_we), 0);
        chk("rst_c_we", longint'(c_we), 0);
        chk("rst_z_raddr", longint'(z_raddr), 0);
        chk("rst_z_wdata", longint'(z_wdata), 0);
        chk("rst_c_addr", longint'(c_addr), 0);
        chk("rst_c_data", longint'(c_data), 0);
        reset = 1'b0;

        rand_colours();
        run_span(10, 14, 'h1000, 0, 0, 1'b1, 1'b0);

        rand_colours();
        s_c1[0] = 'h400; s_dc[0] = 'h400;
        run_span(20, 16, longint'($urandom & 32'h3FFFFFF), rnd_signed(16), 0, 1'b1, 1'b0);

        rand_colours();
        zr  = longint'($urandom & 32'h3FFFFFF);
        dzr = rnd_signed(18);
        run_span(200, 209, zr, dzr, 0, 1'b1, 1'b0);
        run_span(200, 209, zr, dzr, 0, 1'b1, 1'b0);
        run_span(200, 209, zr, dzr, 1, 1'b1, 1'b0);
        run_span(209, 200, zr, dzr, 2, 1'b0, 1'b0);

        rand_colours();
        s_c1[0] = 'h3FFC00; s_dc[0] = 'h800;
        run_span(300, 306, zr, dzr, 2, 1'b1, 1'b0);

        run_span(5, 5, zr, dzr, 2, 1'b1, 1'b0);
        pulse_pol(1'b1, 1'b0);
        rand_colours();
        run_span(400, 404, zr, dzr, 2, 1'b1, 1'b0);
        pulse_pol(1'b1, 1'b1);
        run_span(410, 414, zr, dzr, 2, 1'b1, 1'b0);

        rand_colours();
        run_span(500, 508, zr, dzr, 2, 1'b1, 1'b1);
        run_span(500, 508, zr, dzr, 0, 1'b1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int a, b, len;
            a   = int'($urandom_range(0, (1 << XW) - 1));
            len = int'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 1) b = (a + len > (1 << XW) - 1) ? (1 << XW) - 1 : a + len;
            else b = (a - len < 0) ? 0 : a - len;
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom_range(600, 620));
                b = int'($urandom_range(600, 620));
            end
            rand_colours();
            if ($urandom_range(0, 4) == 0) pulse_pol(1'b1, $urandom_range(0, 2) == 0);
            run_span(a, b, longint'($urandom & 32'h3FFFFFF), rnd_signed(int'($urandom_range(4, ZW))),
                     int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 1'b0);
        end

        repeat (10) @(negedge clk100);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
